// File: rtl/proc_pkg.sv
// Shared definitions for the 13-bit multi-cycle processor: widths, opcodes,
// instruction field positions, operand-fetch FSM encoding and field helpers.
package proc_pkg;

  localparam int DATA_W = 13;
  localparam int NREG   = 8;
  localparam int OPC_W  = 4;
  localparam int RIDX_W = 3;

  localparam logic [OPC_W-1:0] NOP = 4'd0;
  localparam logic [OPC_W-1:0] ADD = 4'd1;
  localparam logic [OPC_W-1:0] SUB = 4'd2;
  localparam logic [OPC_W-1:0] MUL = 4'd3;
  localparam logic [OPC_W-1:0] DIV = 4'd4;
  localparam logic [OPC_W-1:0] AND = 4'd5;
  localparam logic [OPC_W-1:0] OR  = 4'd6;
  localparam logic [OPC_W-1:0] XOR = 4'd7;
  localparam logic [OPC_W-1:0] J   = 4'd8;
  localparam logic [OPC_W-1:0] BEQ = 4'd9;
  localparam logic [OPC_W-1:0] BGT = 4'd10;
  localparam logic [OPC_W-1:0] BLT = 4'd11;
  localparam logic [OPC_W-1:0] BNE = 4'd12;
  localparam logic [OPC_W-1:0] SW  = 4'd13;
  localparam logic [OPC_W-1:0] LD  = 4'd14;
  localparam logic [OPC_W-1:0] LSL = 4'd15;

  localparam int OPC_MSB = 12;
  localparam int OPC_LSB = 9;
  localparam int RD_MSB  = 8;
  localparam int RD_LSB  = 6;
  localparam int RS1_MSB = 5;
  localparam int RS1_LSB = 3;
  localparam int RS2_MSB = 2;
  localparam int RS2_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    ISSUE = 2'd2
  } fetch_state_t;

  function automatic logic [OPC_W-1:0] inst_opcode(input logic [DATA_W-1:0] inst);
    return inst[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [RIDX_W-1:0] inst_rd(input logic [DATA_W-1:0] inst);
    return inst[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [RIDX_W-1:0] inst_rs1(input logic [DATA_W-1:0] inst);
    return inst[RS1_MSB:RS1_LSB];
  endfunction

  function automatic logic [RIDX_W-1:0] inst_rs2(input logic [DATA_W-1:0] inst);
    return inst[RS2_MSB:RS2_LSB];
  endfunction

endpackage

// File: rtl/reg_file_8x13.sv
// 8 x 13-bit architectural register file: two asynchronous read ports, one
// synchronous write port, R0 hardwired to zero, asynchronous active-low clear.
module reg_file_8x13
  import proc_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [RIDX_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [RIDX_W-1:0] i_raddr_a,
  input  logic [RIDX_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] regs [NREG];

  // Storage: cleared on reset; writes to R0 are dropped so it stays zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      regs[i_waddr] <= i_wdata;
    end
  end

  // Read ports: R0 is forced to zero independent of storage contents.
  always_comb begin
    o_rdata_a = (i_raddr_a == '0) ? '0 : regs[i_raddr_a];
    o_rdata_b = (i_raddr_b == '0) ? '0 : regs[i_raddr_b];
  end

endmodule

// File: rtl/alu_operand_fetch.sv
// Decode / operand-fetch stage in front of the ALU. Latches one instruction,
// reads rs1/rs2 from the register file and presents registered operands.
// Optional macro OPFETCH_WB_BYPASS_EN: forward same-cycle writeback data into
// the operand snapshot taken in READ (default: read-before-write).
//
// state | meaning
// IDLE  | ready for an instruction, latches i_inst on i_inst_valid
// READ  | register file read, operands/opcode/rd captured into outputs
// ISSUE | o_valid high, outputs held until i_alu_ready
module alu_operand_fetch
  import proc_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_inst,
  input  logic              i_inst_valid,
  output logic              o_inst_ready,
  input  logic              i_wb_en,
  input  logic [RIDX_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [OPC_W-1:0]  o_opcode,
  output logic [DATA_W-1:0] o_dataA,
  output logic [DATA_W-1:0] o_dataB,
  output logic [RIDX_W-1:0] o_rd,
  output logic              o_valid,
  input  logic              i_alu_ready
);

  fetch_state_t      state;
  logic [DATA_W-1:0] inst_q;
  logic [RIDX_W-1:0] rs1;
  logic [RIDX_W-1:0] rs2;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;

  assign rs1 = inst_rs1(inst_q);
  assign rs2 = inst_rs2(inst_q);

  reg_file_8x13 u_reg_file (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_we      (i_wb_en),
    .i_waddr   (i_wb_addr),
    .i_wdata   (i_wb_data),
    .i_raddr_a (rs1),
    .i_raddr_b (rs2),
    .o_rdata_a (rf_a),
    .o_rdata_b (rf_b)
  );

  // Operand select: register value, optionally overridden by a same-cycle write.
  always_comb begin
    opnd_a = rf_a;
    opnd_b = rf_b;
`ifdef OPFETCH_WB_BYPASS_EN
    if (i_wb_en && (i_wb_addr == rs1) && (rs1 != '0)) opnd_a = i_wb_data;
    if (i_wb_en && (i_wb_addr == rs2) && (rs2 != '0)) opnd_b = i_wb_data;
`endif
  end

  // Sequencer with registered handshake and operand outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      inst_q       <= '0;
      o_inst_ready <= 1'b1;
      o_valid      <= 1'b0;
      o_opcode     <= NOP;
      o_dataA      <= '0;
      o_dataB      <= '0;
      o_rd         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_inst_valid) begin
            inst_q       <= i_inst;
            o_inst_ready <= 1'b0;
            state        <= READ;
          end
        end
        READ: begin
          o_dataA  <= opnd_a;
          o_dataB  <= opnd_b;
          o_opcode <= inst_opcode(inst_q);
          o_rd     <= inst_rd(inst_q);
          o_valid  <= 1'b1;
          state    <= ISSUE;
        end
        ISSUE: begin
          if (i_alu_ready) begin
            o_valid      <= 1'b0;
            o_inst_ready <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          o_valid      <= 1'b0;
          o_inst_ready <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_fetch.sv
module tb_alu_operand_fetch;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic [12:0] i_inst = '0;
  logic        i_inst_valid = 1'b0;
  logic        o_inst_ready;
  logic        i_wb_en = 1'b0;
  logic [2:0]  i_wb_addr = '0;
  logic [12:0] i_wb_data = '0;
  logic [3:0]  o_opcode;
  logic [12:0] o_dataA;
  logic [12:0] o_dataB;
  logic [2:0]  o_rd;
  logic        o_valid;
  logic        i_alu_ready = 1'b1;

  int n_total = 0;
  int n_pass  = 0;

  alu_operand_fetch dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_inst       (i_inst),
    .i_inst_valid (i_inst_valid),
    .o_inst_ready (o_inst_ready),
    .i_wb_en      (i_wb_en),
    .i_wb_addr    (i_wb_addr),
    .i_wb_data    (i_wb_data),
    .o_opcode     (o_opcode),
    .o_dataA      (o_dataA),
    .o_dataB      (o_dataB),
    .o_rd         (o_rd),
    .o_valid      (o_valid),
    .i_alu_ready  (i_alu_ready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [12:0] exp_a;
    logic [12:0] exp_b;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [12:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2};
  endfunction

  // called at a negedge; returns at the negedge after the register write edge
  task automatic wr(input logic [2:0] addr, input logic [12:0] data);
    i_wb_en = 1'b1; i_wb_addr = addr; i_wb_data = data;
    @(negedge i_clk);
    i_wb_en = 1'b0;
  endtask

  // called at a negedge; returns at the negedge after the accept edge (state READ)
  task automatic send(input logic [12:0] w);
    int n = 0;
    while (!o_inst_ready && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_inst_ready) chk("ready_timeout", o_inst_ready, 1);
    i_inst = w; i_inst_valid = 1'b1;
    @(negedge i_clk);
    i_inst_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] w1;
    logic [12:0] exp_byp;

    vecs[0] = '{4'd1,  3'd1, 3'd2, 3'd3, 13'h0003, 13'h0007};
    vecs[1] = '{4'd2,  3'd7, 3'd4, 3'd1, 13'h1FFF, 13'h0005};
    vecs[2] = '{4'd8,  3'd0, 3'd7, 3'd7, 13'h0ABC, 13'h0ABC};
    vecs[3] = '{4'd0,  3'd2, 3'd0, 3'd0, 13'h0000, 13'h0000};
    vecs[4] = '{4'd15, 3'd6, 3'd6, 3'd5, 13'h1000, 13'h0111};
    vecs[5] = '{4'd7,  3'd3, 3'd0, 3'd4, 13'h0000, 13'h1FFF};

    // reset
    #2 i_rst_n = 1'b0;
    @(negedge i_clk);
    chk("rst_ready", o_inst_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_opcode", o_opcode, 0);
    chk("rst_dataA", o_dataA, 0);
    chk("rst_dataB", o_dataB, 0);
    chk("rst_rd", o_rd, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // preload, including an attempted write to R0
    wr(3'd1, 13'd5);
    wr(3'd2, 13'd3);
    wr(3'd3, 13'd7);
    wr(3'd4, 13'h1FFF);
    wr(3'd5, 13'h0111);
    wr(3'd6, 13'h1000);
    wr(3'd7, 13'h0ABC);
    wr(3'd0, 13'h1FFF);

    // table: accept, READ, ISSUE with ALU ready, back to IDLE
    chk("add_word", mk(vecs[0].op, vecs[0].rd, vecs[0].rs1, vecs[0].rs2), 13'h0253);
    for (int i = 0; i < 6; i++) begin
      send(mk(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2));
      chk($sformatf("v%0d_read_valid", i), o_valid, 0);
      chk($sformatf("v%0d_read_ready", i), o_inst_ready, 0);
      @(negedge i_clk);
      chk($sformatf("v%0d_valid", i), o_valid, 1);
      chk($sformatf("v%0d_opcode", i), o_opcode, vecs[i].op);
      chk($sformatf("v%0d_rd", i), o_rd, vecs[i].rd);
      chk($sformatf("v%0d_dataA", i), o_dataA, vecs[i].exp_a);
      chk($sformatf("v%0d_dataB", i), o_dataB, vecs[i].exp_b);
      @(negedge i_clk);
      chk($sformatf("v%0d_done_valid", i), o_valid, 0);
      chk($sformatf("v%0d_done_ready", i), o_inst_ready, 1);
    end

    // ISSUE hold with ALU stalled; writeback during ISSUE must not disturb operands
    i_alu_ready = 1'b0;
    send(mk(4'd1, 3'd4, 3'd2, 3'd1));
    @(negedge i_clk);
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        i_wb_en = 1'b1; i_wb_addr = 3'd2; i_wb_data = 13'h0055;
      end
      @(negedge i_clk);
      i_wb_en = 1'b0;
      chk($sformatf("hold%0d_valid", k), o_valid, 1);
      chk($sformatf("hold%0d_ready", k), o_inst_ready, 0);
      chk($sformatf("hold%0d_opcode", k), o_opcode, 1);
      chk($sformatf("hold%0d_rd", k), o_rd, 4);
      chk($sformatf("hold%0d_dataA", k), o_dataA, 13'h0003);
      chk($sformatf("hold%0d_dataB", k), o_dataB, 13'h0005);
    end
    i_alu_ready = 1'b1;
    @(negedge i_clk);
    chk("hold_release_valid", o_valid, 0);
    chk("hold_release_ready", o_inst_ready, 1);
    send(mk(4'd3, 3'd1, 3'd2, 3'd0));
    @(negedge i_clk);
    chk("wb_visible_dataA", o_dataA, 13'h0055);
    @(negedge i_clk);

    // write to rs1 during READ: forwarded or read-before-write
`ifdef OPFETCH_WB_BYPASS_EN
    exp_byp = 13'h0AAA;
`else
    exp_byp = 13'h0111;
`endif
    send(mk(4'd1, 3'd1, 3'd5, 3'd3));
    i_wb_en = 1'b1; i_wb_addr = 3'd5; i_wb_data = 13'h0AAA;
    @(negedge i_clk);
    i_wb_en = 1'b0;
    chk("bypass_dataA", o_dataA, exp_byp);
    chk("bypass_dataB", o_dataB, 13'h0007);
    @(negedge i_clk);
    send(mk(4'd1, 3'd1, 3'd5, 3'd5));
    @(negedge i_clk);
    chk("after_wb_dataA", o_dataA, 13'h0AAA);
    chk("after_wb_dataB", o_dataB, 13'h0AAA);
    @(negedge i_clk);

    // i_inst_valid outside IDLE is ignored
    i_alu_ready = 1'b0;
    w1 = mk(4'd2, 3'd2, 3'd1, 3'd3);
    send(w1);
    i_inst = mk(4'd14, 3'd7, 3'd4, 3'd6); i_inst_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      chk($sformatf("ign%0d_opcode", k), o_opcode, 2);
      chk($sformatf("ign%0d_rd", k), o_rd, 2);
      chk($sformatf("ign%0d_dataA", k), o_dataA, 13'h0005);
      chk($sformatf("ign%0d_dataB", k), o_dataB, 13'h0007);
      chk($sformatf("ign%0d_valid", k), o_valid, 1);
    end
    i_inst_valid = 1'b0; i_alu_ready = 1'b1;
    @(negedge i_clk);
    chk("ign_idle_valid", o_valid, 0);
    @(negedge i_clk);
    chk("ign_no_accept_ready", o_inst_ready, 1);
    chk("ign_no_accept_valid", o_valid, 0);

    // asynchronous reset during ISSUE
    i_alu_ready = 1'b0;
    send(mk(4'd1, 3'd3, 3'd1, 3'd3));
    @(negedge i_clk);
    chk("pre_rst_valid", o_valid, 1);
    chk("pre_rst_dataA", o_dataA, 13'h0005);
    #1 i_rst_n = 1'b0;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_ready", o_inst_ready, 1);
    chk("arst_opcode", o_opcode, 0);
    chk("arst_dataA", o_dataA, 0);
    chk("arst_dataB", o_dataB, 0);
    chk("arst_rd", o_rd, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1; i_alu_ready = 1'b1;
    @(negedge i_clk);
    send(mk(4'd1, 3'd1, 3'd1, 3'd3));
    @(negedge i_clk);
    chk("post_rst_valid", o_valid, 1);
    chk("post_rst_R1", o_dataA, 0);
    chk("post_rst_R3", o_dataB, 0);
    @(negedge i_clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
